// File: rtl/sys_hex_display_pkg.sv
// Shared constants for the eight-digit hex display: digit count,
// active-low segment codes ({g,f,e,d,c,b,a}) and the all-off anode pattern.
package sys_disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] ANODES_OFF = 8'hFF;

endpackage

// File: rtl/sys_hex_display_if.sv
// Display port bundle: the upstream debug word/strobe and the board-side
// anode/segment drive. master = word source, slave = display driver.
interface sys_hex_display_if;

  logic [31:0] DISP_value;
  logic        DISP_valid;
  logic [7:0]  DISP_dp_mask;
  logic        DISP_enable;
  logic [7:0]  DISP_an;
  logic [6:0]  DISP_seg;
  logic        DISP_dp;
  logic        DISP_frame;

  modport master (
    output DISP_value, DISP_valid, DISP_dp_mask, DISP_enable,
    input  DISP_an, DISP_seg, DISP_dp, DISP_frame
  );

  modport slave (
    input  DISP_value, DISP_valid, DISP_dp_mask, DISP_enable,
    output DISP_an, DISP_seg, DISP_dp, DISP_frame
  );

endinterface

// File: rtl/sys_hex_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment code ({g,f,e,d,c,b,a}).
module hex_to_seg7
  import sys_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sys_hex_display.sv
// Time-multiplexed 8-digit hex display driver with frame-aligned double buffering.
// Define DISP_LZ_BLANK_EN to blank leading-zero digits (dp-marked digits stay lit).
module sys_hex_display
  import sys_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input logic          SYS_clk,
  input logic          SYS_reset_n,
  sys_hex_display_if.slave disp
);

  localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  logic             tick;
  logic             boundary;
  logic             scan_on;
  logic             frame_start;
  logic [31:0]      pend_val;
  logic [7:0]       pend_dp;
  logic [31:0]      disp_val;
  logic [7:0]       disp_dp;
  logic [3:0]       nibble;
  logic [6:0]       seg_code;
  logic [7:0]       blank;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic             frame_q;

  assign tick     = (presc == PW'(REFRESH_DIV - 1));
  assign boundary = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign nibble   = disp_val[{idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_code)
  );

`ifdef DISP_LZ_BLANK_EN
  // A digit is blank when it and every nibble above it are zero; digit 0 never blanks.
  always_comb begin
    blank = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      blank[k] = ((disp_val >> (4 * k)) == 32'd0) && !disp_dp[k];
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      presc       <= '0;
      idx         <= '0;
      scan_on     <= 1'b0;
      frame_start <= 1'b0;
      pend_val    <= '0;
      pend_dp     <= '0;
      disp_val    <= '0;
      disp_dp     <= '0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      frame_start <= boundary;
      if (tick) begin
        idx     <= idx + 1'b1;
        scan_on <= 1'b1;
      end
      if (disp.DISP_valid) begin
        pend_val <= disp.DISP_value;
        pend_dp  <= disp.DISP_dp_mask;
      end
      // A strobe coinciding with the frame boundary bypasses the pending buffer.
      if (boundary) begin
        disp_val <= disp.DISP_valid ? disp.DISP_value   : pend_val;
        disp_dp  <= disp.DISP_valid ? disp.DISP_dp_mask : pend_dp;
      end
    end
  end

  // Outputs hold their reset pattern until the first prescaler tick after reset.
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      an_q    <= ANODES_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else if (!scan_on) begin
      an_q    <= ANODES_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      an_q    <= (!disp.DISP_enable || blank[idx]) ? ANODES_OFF : ~(8'(1) << idx);
      seg_q   <= seg_code;
      dp_q    <= ~disp_dp[idx];
      frame_q <= frame_start;
    end
  end

  assign disp.DISP_an    = an_q;
  assign disp.DISP_seg   = seg_q;
  assign disp.DISP_dp    = dp_q;
  assign disp.DISP_frame = frame_q;

endmodule
